// File: rtl/alu_result_stage_pkg.sv
// Shared ALU definitions: default widths, wide-result opcodes and the result stage state encoding.
package alu_result_stage_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned OP_W       = 5;

    localparam logic [OP_W-1:0] OP_MUL = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV = 5'b01111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND_LO = 2'd1,
        ST_SEND_HI = 2'd2,
        ST_DONE    = 2'd3
    } stage_state_e;

endpackage

// File: rtl/stage_timeout_counter.sv
// Bus wait counter: clears on load, counts stalled cycles and flags the terminal count.
module stage_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic inc,
    output logic tc_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (inc && !tc_c) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc_c = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/alu_result_stage.sv
// ALU result write-back stage: captures a result and drives it to the bus as one beat (Rz) or two beats (LO, HI).
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned     DATA_W  = DATA_W_DEF,
    parameter logic [OP_W-1:0] MUL_OP  = OP_MUL,
    parameter logic [OP_W-1:0] DIV_OP  = OP_DIV,
    parameter int unsigned     TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                start,
    input  logic [OP_W-1:0]     opcode,
    input  logic [2*DATA_W-1:0] c_in,
    input  logic                abort,
    input  logic                bus_ready,
    output logic [DATA_W-1:0]   z_high,
    output logic [DATA_W-1:0]   z_low,
    output logic [DATA_W-1:0]   bus_out,
    output logic                bus_valid,
    output logic                rz_wr,
    output logic                lo_wr,
    output logic                hi_wr,
    output logic                busy,
    output logic                done,
    output logic                err
);

    stage_state_e      state;
    stage_state_e      state_next;
    logic [OP_W-1:0]   op_q;
    logic [OP_W-1:0]   op_next;
    logic [DATA_W-1:0] z_high_next;
    logic [DATA_W-1:0] z_low_next;
    logic [DATA_W-1:0] bus_out_next;
    logic              err_next;
    logic              in_send;
    logic              tc_c;
    logic              cnt_load;
    logic              cnt_inc;

    function automatic logic is_wide(input logic [OP_W-1:0] op);
        return (op == MUL_OP) || (op == DIV_OP);
    endfunction

    assign in_send  = (state == ST_SEND_LO) || (state == ST_SEND_HI);
    assign cnt_load = (state_next != state);
    assign cnt_inc  = in_send && !bus_ready;

    stage_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst_n (clear),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .tc_c  (tc_c)
    );

    // Next state, capture and timeout decision; abort overrides everything.
    always_comb begin
        state_next  = state;
        op_next     = op_q;
        z_high_next = z_high;
        z_low_next  = z_low;
        err_next    = 1'b0;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        z_high_next = c_in[2*DATA_W-1:DATA_W];
                        z_low_next  = c_in[DATA_W-1:0];
                        op_next     = opcode;
                        state_next  = ST_SEND_LO;
                    end
                end
                ST_SEND_LO: begin
                    if (bus_ready) begin
                        state_next = is_wide(op_q) ? ST_SEND_HI : ST_DONE;
                    end else if (tc_c) begin
                        state_next = ST_IDLE;
                        err_next   = 1'b1;
                    end
                end
                ST_SEND_HI: begin
                    if (bus_ready) begin
                        state_next = ST_DONE;
                    end else if (tc_c) begin
                        state_next = ST_IDLE;
                        err_next   = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus_out_next = '0;
        case (state_next)
            ST_SEND_LO: bus_out_next = z_low_next;
            ST_SEND_HI: bus_out_next = z_high_next;
            default:    bus_out_next = '0;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            z_high    <= '0;
            z_low     <= '0;
            bus_out   <= '0;
            bus_valid <= 1'b0;
            rz_wr     <= 1'b0;
            lo_wr     <= 1'b0;
            hi_wr     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            op_q      <= op_next;
            z_high    <= z_high_next;
            z_low     <= z_low_next;
            bus_out   <= bus_out_next;
            bus_valid <= (state_next == ST_SEND_LO) || (state_next == ST_SEND_HI);
            rz_wr     <= (state_next == ST_SEND_LO) && !is_wide(op_next);
            lo_wr     <= (state_next == ST_SEND_LO) && is_wide(op_next);
            hi_wr     <= (state_next == ST_SEND_HI);
            busy      <= (state_next != ST_IDLE);
            done      <= (state_next == ST_DONE);
            err       <= err_next;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: single/wide beats, backpressure, timeout, abort and async clear.
module tb_alu_result_stage;

    logic        clk;
    logic        clear;
    logic        start;
    logic [4:0]  opcode;
    logic [63:0] c_in;
    logic        abort;
    logic        bus_ready;
    logic [31:0] z_high;
    logic [31:0] z_low;
    logic [31:0] bus_out;
    logic        bus_valid;
    logic        rz_wr;
    logic        lo_wr;
    logic        hi_wr;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic any_done;

    alu_result_stage dut (
        .clk       (clk),
        .clear     (clear),
        .start     (start),
        .opcode    (opcode),
        .c_in      (c_in),
        .abort     (abort),
        .bus_ready (bus_ready),
        .z_high    (z_high),
        .z_low     (z_low),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .rz_wr     (rz_wr),
        .lo_wr     (lo_wr),
        .hi_wr     (hi_wr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [4:0] op, input logic [63:0] val, input logic rdy);
        start     = 1'b1;
        opcode    = op;
        c_in      = val;
        bus_ready = rdy;
        tick();
        start = 1'b0;
    endtask

    task automatic run_add();
        launch(5'b00011, 64'h0000_0000_0000_0007, 1'b1);
        check("add_valid", bus_valid, 1);
        check("add_bus", bus_out, 64'h7);
        check("add_rz", rz_wr, 1);
        check("add_lo", lo_wr, 0);
        check("add_busy", busy, 1);
        tick();
        check("add_done", done, 1);
        check("add_valid_off", bus_valid, 0);
        tick();
        check("add_done_pulse", done, 0);
        check("add_idle", busy, 0);
    endtask

    initial begin
        clear = 1'b0; start = 1'b0; opcode = '0; c_in = '0; abort = 1'b0; bus_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", bus_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_zh", z_high, 0);
        check("rst_bus", bus_out, 0);
        clear = 1'b1;
        tick();

        run_add();

        // Multiply: LO beat then HI beat
        launch(5'b01110, 64'h0000_0001_FFFF_FFFE, 1'b1);
        check("mul_lo_bus", bus_out, 64'hFFFF_FFFE);
        check("mul_lo_tag", lo_wr, 1);
        check("mul_rz_tag", rz_wr, 0);
        tick();
        check("mul_hi_bus", bus_out, 64'h0000_0001);
        check("mul_hi_tag", hi_wr, 1);
        check("mul_hi_lo", lo_wr, 0);
        tick();
        check("mul_done", done, 1);
        tick();
        check("mul_idle", busy, 0);

        // Divide with 5 stalled cycles in SEND_LO
        launch(5'b01111, 64'h1234_5678_9ABC_DEF0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_lo_bus", bus_out, 64'h9ABC_DEF0);
            check("bp_lo_tag", lo_wr, 1);
            tick();
        end
        check("bp_hold_bus", bus_out, 64'h9ABC_DEF0);
        bus_ready = 1'b1;
        tick();
        check("bp_hi_bus", bus_out, 64'h1234_5678);
        check("bp_hi_tag", hi_wr, 1);
        tick();
        check("bp_done", done, 1);
        tick();

        // Timeout: 16 cycles in SEND_LO with ready low
        launch(5'b00011, 64'h0000_0000_0000_00AA, 1'b0);
        any_done = done;
        for (int i = 0; i < 15; i++) begin
            tick();
            any_done = any_done | done;
            check("to_wait_valid", bus_valid, 1);
            check("to_wait_err", err, 0);
        end
        tick();
        any_done = any_done | done;
        check("to_err", err, 1);
        check("to_idle", busy, 0);
        check("to_valid_off", bus_valid, 0);
        tick();
        any_done = any_done | done;
        check("to_err_pulse", err, 0);
        check("to_no_done", any_done, 0);

        // Abort collides with start while in SEND_HI
        launch(5'b01110, 64'hCAFE_0001_BEEF_0002, 1'b1);
        tick();
        check("ab_hi_bus", bus_out, 64'hCAFE_0001);
        abort = 1'b1;
        start = 1'b1;
        c_in  = 64'h1111_2222_3333_4444;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("ab_idle", busy, 0);
        check("ab_no_done", done, 0);
        check("ab_valid_off", bus_valid, 0);
        check("ab_zh", z_high, 64'hCAFE_0001);
        check("ab_zl", z_low, 64'hBEEF_0002);
        tick();
        check("ab_still_idle", busy, 0);
        check("ab_no_done2", done, 0);

        // Asynchronous clear during SEND_HI
        launch(5'b01110, 64'h0000_00AB_0000_00CD, 1'b1);
        tick();
        check("rm_hi_tag", hi_wr, 1);
        #2;
        clear = 1'b0;
        #1;
        check("rm_valid", bus_valid, 0);
        check("rm_hi_off", hi_wr, 0);
        check("rm_bus", bus_out, 0);
        check("rm_zh", z_high, 0);
        check("rm_busy", busy, 0);
        tick();
        clear = 1'b1;
        tick();
        check("rm_no_done", done, 0);
        check("rm_no_err", err, 0);
        run_add();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter DATA_W, default 32, data path width of one result half.
REQ-002 Parameter MUL_OP, default 5'b01110, opcode whose result is wide (HI/LO).
REQ-003 Parameter DIV_OP, default 5'b01111, opcode whose result is wide (HI/LO).
REQ-004 Parameter TIMEOUT, default 16, max cycles a bus transfer may wait for ready.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 clear  input  1  reset, asynchronous, active-low (clear=0 resets).
REQ-007 start  input  1  ALU result valid this cycle; capture request (Zin).
REQ-008 opcode  input  5  ALU opcode accompanying c_in.
REQ-009 c_in  input  2*DATA_W  ALU 64-bit result (C_reg).
REQ-010 abort  input  1  synchronous cancel of any in-flight result.
REQ-011 bus_ready  input  1  downstream bus/register file accepts bus_out.
REQ-012 z_high, z_low  output  DATA_W each  captured result halves.
REQ-013 bus_out  output  DATA_W  value being driven to the bus.
REQ-014 bus_valid  output  1  bus_out valid.
REQ-015 rz_wr, lo_wr, hi_wr  output  1 each  destination tag for current beat (Rz, LO, HI).
REQ-016 busy  output  1  state not IDLE.
REQ-017 done  output  1  one-cycle pulse on successful completion.
REQ-018 err  output  1  one-cycle pulse on timeout.

Function
REQ-019 States SHALL be IDLE, SEND_LO, SEND_HI, DONE; encoding fixed in shared package.
REQ-020 IDLE with start=1 and abort=0 SHALL load z_high<=c_in[63:32], z_low<=c_in[31:0], latch opcode, enter SEND_LO next cycle (latency 1).
REQ-021 start SHALL be ignored outside IDLE; z_high/z_low SHALL hold until next accepted start.
REQ-022 SEND_LO: bus_valid=1, bus_out=z_low; lo_wr=1 if latched opcode is MUL_OP or DIV_OP, else rz_wr=1.
REQ-023 A beat SHALL transfer on a cycle with bus_valid=1 and bus_ready=1; bus_out and tags SHALL stay stable until then.
REQ-024 SEND_LO transfer: wide opcode -> SEND_HI, else -> DONE.
REQ-025 SEND_HI: bus_valid=1, bus_out=z_high, hi_wr=1; transfer -> DONE.
REQ-026 DONE: done=1 for exactly one cycle, bus_valid=0, -> IDLE.
REQ-027 Wait counter SHALL clear on each state entry and increment each cycle in SEND_LO/SEND_HI without transfer; reaching TIMEOUT-1 without transfer SHALL pulse err and return to IDLE with no done.
REQ-028 abort=1 SHALL return to IDLE next cycle from any state, no done/err; abort wins over start and bus_ready in the same cycle.
REQ-029 Outside SEND_LO/SEND_HI: bus_valid, rz_wr, lo_wr, hi_wr SHALL be 0 and bus_out SHALL be 0.
REQ-030 At most one of rz_wr, lo_wr, hi_wr SHALL be 1 in any cycle.
REQ-031 Non-wide opcodes SHALL ignore z_high for bus purposes (still captured).

Reset
REQ-032 clear=0 SHALL immediately force IDLE, z_high=z_low=0, latched opcode=0, wait counter=0, all outputs 0.
REQ-033 clear asserted mid-transfer SHALL drop bus_valid asynchronously; no done/err pulse after release.

Structure
REQ-034 State encoding, MUL_OP/DIV_OP opcode constants and DATA_W default SHALL live in the shared ALU package used by the ALU's opcode list.
REQ-035 The wait counter SHALL be one sub-module, stage_timeout_counter (clear-on-load, increment, terminal-count output).

Verification
REQ-036 Add: start, opcode=5'b00011, c_in=64'h0000_0000_0000_0007, bus_ready=1 -> next cycle bus_out=7, rz_wr=1; following cycle done=1.
REQ-037 Mul: opcode=5'b01110, c_in=64'h0000_0001_FFFF_FFFE, bus_ready=1 -> beat1 FFFF_FFFE lo_wr, beat2 0000_0001 hi_wr, then done.
REQ-038 Backpressure: div result, bus_ready=0 for 5 cycles in SEND_LO -> bus_out/lo_wr stable, no advance; ready=1 -> SEND_HI, completes with done.
REQ-039 Timeout: bus_ready held 0 -> err pulse after TIMEOUT=16 cycles in SEND_LO, returns IDLE, done never asserted.
REQ-040 Abort/start collision: abort=1 and start=1 in SEND_HI -> IDLE next cycle, z_high/z_low unchanged, no done.
REQ-041 Reset mid-operation: clear=0 during SEND_HI -> all outputs 0 same cycle; after release start with new c_in behaves as REQ-036.
